// File: rtl/flip_icon_store_if.sv
// Config-stream, read-port and status bundle for flip_icon_store.
// master = stream source / icon reader, slave = the store itself.
interface flip_icon_store_if #(
   parameter int NUM_SPIN        = 256,
   parameter int WR_DATAW        = 64,
   parameter int FLIP_ICON_DEPTH = 1024
);
   localparam int AW = $clog2(FLIP_ICON_DEPTH);

   logic                en_i;
   logic                load_start_i;
   logic                wr_valid_i;
   logic [WR_DATAW-1:0] wr_data_i;
   logic                wr_last_i;
   logic                wr_ready_o;
   logic                ren_i;
   logic [AW:0]         raddr_i;
   logic [NUM_SPIN-1:0] rdata_o;
   logic [AW:0]         icon_last_raddr_plus_one_o;
   logic                load_done_o;
   logic                overflow_o;

   modport master (
      output en_i, load_start_i, wr_valid_i, wr_data_i, wr_last_i, ren_i, raddr_i,
      input  wr_ready_o, rdata_o, icon_last_raddr_plus_one_o, load_done_o, overflow_o
   );

   modport slave (
      input  en_i, load_start_i, wr_valid_i, wr_data_i, wr_last_i, ren_i, raddr_i,
      output wr_ready_o, rdata_o, icon_last_raddr_plus_one_o, load_done_o, overflow_o
   );
endinterface

// File: rtl/flip_icon_store.sv
// Flip-icon store: packs narrow config beats LSB-first into NUM_SPIN-bit icons,
// then serves 1-cycle-latency icon reads once the set is loaded.
//
// state   | meaning
// --------+-----------------------------------------------------------
// S_IDLE  | after reset, nothing loaded, waits for load_start
// S_LOAD  | accepting config beats (ready drops once the store is full)
// S_READY | icon set complete, read port active
module flip_icon_store #(
   parameter int NUM_SPIN        = 256,
   parameter int WR_DATAW        = 64,
   parameter int FLIP_ICON_DEPTH = 1024
) (
   input  logic            clk_i,
   input  logic            rst_ni,
   flip_icon_store_if.slave bus
);
   localparam int BEATS = NUM_SPIN / WR_DATAW;
   localparam int AW    = $clog2(FLIP_ICON_DEPTH);
   localparam int BW    = (BEATS > 1) ? $clog2(BEATS) : 1;

   typedef enum logic [1:0] {S_IDLE, S_LOAD, S_READY} state_t;

   state_t              state_q, state_d;
   logic [BW-1:0]       beat_cnt_q;
   logic [AW:0]         icon_cnt_q;
   logic [NUM_SPIN-1:0] pack_q, pack_next;
   logic [NUM_SPIN-1:0] rdata_q;
   logic                overflow_q;
   logic [NUM_SPIN-1:0] mem [FLIP_ICON_DEPTH];

   logic start, full, wr_ready, accept, commit;

   // Handshake decode; load_start owns the cycle, so any beat alongside it is dropped.
   always_comb begin
      start     = bus.en_i & bus.load_start_i;
      full      = (icon_cnt_q == (AW+1)'(FLIP_ICON_DEPTH));
      wr_ready  = bus.en_i & (state_q == S_LOAD) & ~bus.load_start_i & ~full;
      accept    = wr_ready & bus.wr_valid_i;
      commit    = accept & ((beat_cnt_q == BW'(BEATS - 1)) | bus.wr_last_i);
      pack_next = pack_q;
      pack_next[int'(beat_cnt_q) * WR_DATAW +: WR_DATAW] = bus.wr_data_i;
   end

   // Next-state logic; IDLE is left only via load_start and never re-entered.
   always_comb begin
      state_d = state_q;
      if (start) begin
         state_d = S_LOAD;
      end else if ((state_q == S_LOAD) && commit && bus.wr_last_i) begin
         state_d = S_READY;
      end
   end

   // State register.
   always_ff @(posedge clk_i) begin
      if (!rst_ni) begin
         state_q <= S_IDLE;
      end else if (bus.en_i) begin
         state_q <= state_d;
      end
   end

   // Beat packing, icon count and sticky overflow flag.
   always_ff @(posedge clk_i) begin
      if (!rst_ni) begin
         beat_cnt_q <= '0;
         icon_cnt_q <= '0;
         pack_q     <= '0;
         overflow_q <= 1'b0;
      end else if (start) begin
         beat_cnt_q <= '0;
         icon_cnt_q <= '0;
         pack_q     <= '0;
         overflow_q <= 1'b0;
      end else if (bus.en_i) begin
         if (accept) begin
            if (commit) begin
               beat_cnt_q <= '0;
               icon_cnt_q <= icon_cnt_q + (AW+1)'(1);
               pack_q     <= '0;
            end else begin
               beat_cnt_q <= beat_cnt_q + BW'(1);
               pack_q     <= pack_next;
            end
         end
         if ((state_q == S_LOAD) && full && bus.wr_valid_i) begin
            overflow_q <= 1'b1;
         end
      end
   end

   // Icon storage write; contents survive reset, but a reset edge must not commit.
   always_ff @(posedge clk_i) begin
      if (rst_ni && commit) begin
         mem[icon_cnt_q[AW-1:0]] <= pack_next;
      end
   end

   // Registered read port; addresses past the loaded count read as zero.
   always_ff @(posedge clk_i) begin
      if (!rst_ni) begin
         rdata_q <= '0;
      end else if (bus.en_i && bus.ren_i && (state_q == S_READY)) begin
         rdata_q <= (bus.raddr_i < icon_cnt_q) ? mem[bus.raddr_i[AW-1:0]] : '0;
      end
   end

   assign bus.wr_ready_o                 = wr_ready;
   assign bus.rdata_o                    = rdata_q;
   assign bus.icon_last_raddr_plus_one_o = icon_cnt_q;
   assign bus.load_done_o                = (state_q == S_READY);
   assign bus.overflow_o                 = overflow_q;
endmodule

// File: tb/tb_flip_icon_store.sv
// Bench for flip_icon_store (NUM_SPIN=256, WR_DATAW=64, depth 4): directed
// scenarios followed by random traffic, all against a transaction-level model.
module tb_flip_icon_store;
   localparam int NS    = 256;
   localparam int W     = 64;
   localparam int D     = 4;
   localparam int BEATS = NS / W;

   logic clk = 1'b0;
   logic rst_n;
   always #5 clk = ~clk;

   flip_icon_store_if #(.NUM_SPIN(NS), .WR_DATAW(W), .FLIP_ICON_DEPTH(D)) bus ();

   flip_icon_store #(.NUM_SPIN(NS), .WR_DATAW(W), .FLIP_ICON_DEPTH(D)) dut (
      .clk_i (clk),
      .rst_ni(rst_n),
      .bus   (bus)
   );

   int n_vec = 0;
   int n_err = 0;

   // Reference model: phase 0=idle 1=loading 2=ready, beats of the open icon in a queue.
   int           m_phase;
   int           m_cnt;
   bit           m_ovf;
   logic [NS-1:0] m_rdata;
   logic [NS-1:0] m_mem [D];
   logic [W-1:0]  m_cur [$];

   task automatic check(input string tag, input logic [NS-1:0] obs, input logic [NS-1:0] exp);
      n_vec++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic check_outputs();
      check("rdata", bus.rdata_o, m_rdata);
      check("count", NS'(bus.icon_last_raddr_plus_one_o), NS'(m_cnt));
      check("load_done", NS'(bus.load_done_o), NS'(m_phase == 2));
      check("overflow", NS'(bus.overflow_o), NS'(m_ovf));
   endtask

   task automatic do_reset();
      rst_n = 1'b0;
      bus.en_i = 1'b1; bus.load_start_i = 1'b0; bus.wr_valid_i = 1'b0;
      bus.wr_data_i = '0; bus.wr_last_i = 1'b0; bus.ren_i = 1'b0; bus.raddr_i = '0;
      @(posedge clk); #1;
      rst_n = 1'b1;
      m_phase = 0; m_cnt = 0; m_ovf = 1'b0; m_rdata = '0; m_cur.delete();
      check("rst_wr_ready", NS'(bus.wr_ready_o), '0);
      check_outputs();
   endtask

   task automatic step(input bit en, input bit ls, input bit v, input logic [W-1:0] d,
                       input bit last, input bit ren, input int ra);
      bit exp_ready;
      logic [NS-1:0] icon;
      bus.en_i = en; bus.load_start_i = ls; bus.wr_valid_i = v; bus.wr_data_i = d;
      bus.wr_last_i = last; bus.ren_i = ren; bus.raddr_i = 3'(ra);
      exp_ready = en && (m_phase == 1) && !ls && (m_cnt < D);
      #1;
      check("wr_ready", NS'(bus.wr_ready_o), NS'(exp_ready));
      @(posedge clk);
      if (en) begin
         if (ren && m_phase == 2) m_rdata = (ra < m_cnt) ? m_mem[ra] : '0;
         if (ls) begin
            m_phase = 1; m_cnt = 0; m_ovf = 1'b0; m_cur.delete();
         end else begin
            if (m_phase == 1 && m_cnt == D && v) m_ovf = 1'b1;
            if (exp_ready && v) begin
               m_cur.push_back(d);
               if (m_cur.size() == BEATS || last) begin
                  icon = '0;
                  foreach (m_cur[i]) icon[i*W +: W] = m_cur[i];
                  m_mem[m_cnt] = icon;
                  m_cnt++;
                  m_cur.delete();
                  if (last) m_phase = 2;
               end
            end
         end
      end
      #1;
      check_outputs();
   endtask

   task automatic idle_step();
      step(1, 0, 0, '0, 0, 0, 0);
   endtask

   task automatic rd(input int ra);
      step(1, 0, 0, '0, 0, 1, ra);
   endtask

   initial begin
      rst_n = 1'b0;
      bus.en_i = 1'b0; bus.load_start_i = 1'b0; bus.wr_valid_i = 1'b0;
      bus.wr_data_i = '0; bus.wr_last_i = 1'b0; bus.ren_i = 1'b0; bus.raddr_i = '0;
      repeat (2) @(posedge clk);
      #1;
      do_reset();
      check("rst_rdata_const", bus.rdata_o, '0);

      // Two full icons from beats 1..8, last on beat 8.
      step(1, 1, 0, '0, 0, 0, 0);
      for (int i = 1; i <= 8; i++) step(1, 0, 1, W'(i), i == 8, 0, 0);
      check("s1_count", NS'(bus.icon_last_raddr_plus_one_o), NS'(2));
      check("s1_done", NS'(bus.load_done_o), NS'(1));
      rd(1);
      check("s1_icon1", bus.rdata_o, {64'h8, 64'h7, 64'h6, 64'h5});

      // Partial final icon: unfilled slots read back as zero.
      step(1, 1, 0, '0, 0, 0, 0);
      for (int i = 1; i <= 5; i++) step(1, 0, 1, W'(i), i == 5, 0, 0);
      check("s2_count", NS'(bus.icon_last_raddr_plus_one_o), NS'(2));
      rd(1);
      check("s2_icon1", bus.rdata_o, {64'h0, 64'h0, 64'h0, 64'h5});
      rd(0);
      check("s2_icon0", bus.rdata_o, {64'h4, 64'h3, 64'h2, 64'h1});

      // Fill the store without last, then offer one more beat.
      step(1, 1, 0, '0, 0, 0, 0);
      for (int i = 0; i < 16; i++) step(1, 0, 1, {$urandom, $urandom}, 0, 0, 0);
      check("s3_count", NS'(bus.icon_last_raddr_plus_one_o), NS'(4));
      step(1, 0, 1, {$urandom, $urandom}, 0, 0, 0);
      check("s3_ready", NS'(bus.wr_ready_o), NS'(0));
      check("s3_ovf", NS'(bus.overflow_o), NS'(1));
      check("s3_not_done", NS'(bus.load_done_o), NS'(0));
      step(1, 0, 1, {$urandom, $urandom}, 1, 0, 0);
      check("s3_stay_load", NS'(bus.load_done_o), NS'(0));

      // load_start clears overflow; beat offered alongside it is dropped.
      step(1, 1, 1, {$urandom, $urandom}, 0, 0, 0);
      check("s4_ovf_clr", NS'(bus.overflow_o), NS'(0));
      check("s4_count", NS'(bus.icon_last_raddr_plus_one_o), NS'(0));

      // Exactly full set with last on the final beat.
      for (int i = 0; i < 16; i++) step(1, 0, 1, {$urandom, $urandom}, i == 15, 0, 0);
      check("s5_count", NS'(bus.icon_last_raddr_plus_one_o), NS'(4));
      check("s5_done", NS'(bus.load_done_o), NS'(1));
      rd(3);
      rd(4);
      check("s5_oob", bus.rdata_o, '0);

      // load_start in READY with a simultaneous beat.
      step(1, 1, 1, 64'hdead, 1, 0, 0);
      check("s6_count", NS'(bus.icon_last_raddr_plus_one_o), NS'(0));
      check("s6_load", NS'(bus.load_done_o), NS'(0));

      // Back-to-back reads, out-of-range read, read during LOAD, enable low.
      for (int i = 0; i < 8; i++) step(1, 0, 1, {$urandom, $urandom}, i == 7, 0, 0);
      rd(0); rd(1); rd(0); rd(2); rd(7); rd(1);
      step(1, 1, 0, '0, 0, 0, 0);
      rd(0);
      step(1, 0, 1, {$urandom, $urandom}, 1, 0, 0);
      step(0, 1, 1, {$urandom, $urandom}, 1, 1, 0);
      rd(0);

      // Reset mid-load discards the partial set.
      step(1, 1, 0, '0, 0, 0, 0);
      step(1, 0, 1, {$urandom, $urandom}, 0, 0, 0);
      step(1, 0, 1, {$urandom, $urandom}, 0, 0, 0);
      do_reset();
      rd(0);

      // Random traffic.
      for (int n = 0; n < 600; n++) begin
         step(($urandom_range(7) != 0), ($urandom_range(15) == 0), $urandom_range(1),
              {$urandom, $urandom}, ($urandom_range(7) == 0), $urandom_range(1),
              int'($urandom_range(7)));
      end

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end
endmodule
